// File: rtl/mem_access.sv
// MEM pipeline stage: issues one data-memory access per load/store, stalls the
// pipeline until completion or timeout, and aligns/extends load data.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] regcData_i,
  input  logic        regcWrite_i,
  input  logic [4:0]  regcAddr_i,
  input  logic [5:0]  op_i,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] memData_i,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stallreq_o,
  output logic [31:0] inst_o,
  output logic [31:0] regcData_o,
  output logic        regcWrite_o,
  output logic [4:0]  regcAddr_o,
  output logic        align_err_o,
  output logic        bus_err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic [1:0]  state_reg, state_next;
  logic [31:0] load_reg, load_next;
  logic [7:0]  timeout_reg, timeout_next;
  logic        bus_err_reg, bus_err_next;
  logic [7:0]  timeout_inc;

  logic        is_load, is_store, sz_byte, sz_half, sz_word, ld_signed;
  logic        mem_op, misaligned, issue_ok, req_phase;
  logic [3:0]  be_calc;
  logic [31:0] wdata_lane;
  logic [31:0] load_shift, load_ext;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    sz_byte   = 1'b0;
    sz_half   = 1'b0;
    sz_word   = 1'b0;
    ld_signed = 1'b0;
    case (op_i)
      OP_LB:  begin is_load  = 1'b1; sz_byte = 1'b1; ld_signed = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; sz_half = 1'b1; ld_signed = 1'b1; end
      OP_LW:  begin is_load  = 1'b1; sz_word = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
      OP_SB:  begin is_store = 1'b1; sz_byte = 1'b1; end
      OP_SH:  begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SW:  begin is_store = 1'b1; sz_word = 1'b1; end
      default: ;
    endcase
  end

  assign mem_op      = is_load | is_store;
  assign misaligned  = (sz_word && (memAddr_i[1:0] != 2'b00)) || (sz_half && memAddr_i[0]);
  assign issue_ok    = mem_op && !misaligned;
  assign timeout_inc = timeout_reg + 8'd1;

  always_comb begin
    state_next   = state_reg;
    load_next    = load_reg;
    timeout_next = timeout_reg;
    bus_err_next = bus_err_reg;
    case (state_reg)
      ST_IDLE: begin
        timeout_next = 8'd0;
        bus_err_next = 1'b0;
        if (issue_ok) begin
          if (dm_ack) begin
            state_next = ST_DONE;
            if (is_load) load_next = dm_rdata;
          end else begin
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dm_ack) begin
          state_next = ST_DONE;
          if (is_load) load_next = dm_rdata;
        end else begin
          timeout_next = timeout_inc;
          if (timeout_inc == 8'hFF) begin
            state_next   = ST_DONE;
            bus_err_next = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next   = ST_IDLE;
        timeout_next = 8'd0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      load_reg    <= 32'd0;
      timeout_reg <= 8'd0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      load_reg    <= load_next;
      timeout_reg <= timeout_next;
      bus_err_reg <= bus_err_next;
    end
  end

  // Store lanes: bytes/halves are replicated so the selected lanes carry the data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_lane[gi*8 +: 8] = sz_byte ? memData_i[7:0] :
                                     sz_half ? memData_i[(gi % 2)*8 +: 8] :
                                               memData_i[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    be_calc = 4'b1111;
    if (is_store && sz_byte)      be_calc = 4'b0001 << memAddr_i[1:0];
    else if (is_store && sz_half) be_calc = memAddr_i[1] ? 4'b1100 : 4'b0011;
  end

  assign load_shift = load_reg >> {memAddr_i[1:0], 3'b000};

  always_comb begin
    load_ext = load_reg;
    if (sz_byte)      load_ext = {{24{ld_signed & load_shift[7]}},  load_shift[7:0]};
    else if (sz_half) load_ext = {{16{ld_signed & load_shift[15]}}, load_shift[15:0]};
  end

  // Outputs are gated by rst so an asserted reset clears them without a clock.
  assign req_phase   = (state_reg == ST_IDLE && issue_ok) || (state_reg == ST_REQ);
  assign dm_req      = rst && req_phase;
  assign stallreq_o  = dm_req;
  assign dm_we       = dm_req && is_store;
  assign dm_be       = dm_req ? be_calc : 4'd0;
  assign dm_addr     = dm_req ? {memAddr_i[31:2], 2'b00} : 32'd0;
  assign dm_wdata    = dm_req ? (is_store ? wdata_lane : 32'd0) : 32'd0;
  assign align_err_o = rst && (state_reg == ST_IDLE) && mem_op && misaligned;
  assign bus_err_o   = rst && (state_reg == ST_DONE) && bus_err_reg;

  assign inst_o      = rst ? inst_i : 32'd0;
  assign regcAddr_o  = rst ? regcAddr_i : 5'd0;
  assign regcData_o  = !rst ? 32'd0 :
                       ((state_reg == ST_DONE) && is_load && !bus_err_reg) ? load_ext :
                       regcData_i;
  assign regcWrite_o = rst && regcWrite_i && !stallreq_o && !align_err_o && !bus_err_o;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized loads/stores
// compared against an arithmetic reference model of the memory stage.
module tb_mem_access;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, regcData_i, memAddr_i, memData_i, dm_rdata;
  logic        regcWrite_i, dm_ack;
  logic [4:0]  regcAddr_i;
  logic [5:0]  op_i;
  logic        dm_req, dm_we, stallreq_o, regcWrite_o, align_err_o, bus_err_o;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, inst_o, regcData_o;
  logic [4:0]  regcAddr_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .inst_i(inst_i), .regcData_i(regcData_i), .regcWrite_i(regcWrite_i), .regcAddr_i(regcAddr_i),
    .op_i(op_i), .memAddr_i(memAddr_i), .memData_i(memData_i),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stallreq_o(stallreq_o), .inst_o(inst_o), .regcData_o(regcData_o),
    .regcWrite_o(regcWrite_o), .regcAddr_o(regcAddr_o),
    .align_err_o(align_err_o), .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes (0 = not a memory op).
  function automatic int size_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit is_ld(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int sz = size_of(op);
    longint v = longint'(rdata >> (8 * (addr % 4)));
    if (sz < 4) begin
      v = v % (longint'(1) << (8 * sz));
      if ((op == OP_LB || op == OP_LH) && v >= (longint'(1) << (8 * sz - 1)))
        v = v - (longint'(1) << (8 * sz));
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_be(input logic [5:0] op, input logic [31:0] addr);
    int sz = size_of(op);
    if (is_ld(op) || sz == 4) return 32'hF;
    return ((32'd1 << sz) - 32'd1) << (addr % 4);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] data);
    if (is_ld(op)) return 32'd0;
    case (size_of(op))
      1:       return (data & 32'hFF) * 32'h01010101;
      2:       return (data & 32'hFFFF) * 32'h00010001;
      default: return data;
    endcase
  endfunction

  task automatic set_inputs(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
    op_i        = op;
    memAddr_i   = addr;
    memData_i   = data;
    inst_i      = $urandom;
    regcData_i  = $urandom;
    regcWrite_i = 1'($urandom);
    regcAddr_i  = 5'($urandom);
  endtask

  // One instruction: ack_at = request cycle carrying dm_ack (0 = never, expect timeout).
  task automatic do_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input int ack_at, input logic [31:0] rdata);
    int  sz    = size_of(op);
    bit  mis   = (sz != 0) && ((addr % sz) != 0);
    int  stall = 0;
    @(negedge clk);
    set_inputs(op, addr, data);
    if (sz == 0 || mis) begin
      dm_ack   = 1'($urandom);
      dm_rdata = $urandom;
      #1;
      chk("pass_inst",  inst_o,      inst_i);
      chk("pass_addr",  regcAddr_o,  regcAddr_i);
      chk("idle_req",   dm_req,      0);
      chk("idle_stall", stallreq_o,  0);
      chk("align_err",  align_err_o, mis);
      chk("idle_wr",    regcWrite_o, mis ? 0 : regcWrite_i);
      if (!mis) chk("pass_data", regcData_o, regcData_i);
      $display("txn op=%06b addr=%08h %s", op, addr, mis ? "misaligned" : "non-mem");
      return;
    end
    for (int c = 1; c <= 300; c++) begin
      if (c > 1) @(negedge clk);
      dm_ack   = (c == ack_at);
      dm_rdata = (c == ack_at) ? rdata : $urandom;
      #1;
      stall++;
      chk("req_stall", stallreq_o, 1);
      chk("req_req",   dm_req,     1);
      chk("req_wr",    regcWrite_o, 0);
      chk("req_we",    dm_we,      !is_ld(op));
      chk("req_be",    dm_be,      exp_be(op, addr));
      chk("req_addr",  dm_addr,    addr & 32'hFFFF_FFFC);
      chk("req_wdata", dm_wdata,   exp_wdata(op, data));
      if (c == ack_at) break;
      if (ack_at == 0 && c == 256) break;
    end
    @(negedge clk);
    dm_ack   = 1'($urandom);
    dm_rdata = $urandom;
    #1;
    chk("done_stall", stallreq_o, 0);
    chk("done_req",   dm_req,     0);
    chk("done_buserr", bus_err_o, ack_at == 0);
    chk("done_wr",    regcWrite_o, (ack_at == 0) ? 0 : regcWrite_i);
    if (ack_at != 0)
      chk("done_data", regcData_o, is_ld(op) ? exp_load(op, addr, rdata) : regcData_i);
    $display("txn op=%06b addr=%08h stall=%0d %s", op, addr, stall, ack_at == 0 ? "timeout" : "ok");
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    rst = 1'b0;
    dm_ack = 1'b1;
    dm_rdata = 32'hFFFF_FFFF;
    set_inputs(OP_LW, 32'h100, 32'h1234);
    #1;
    chk("rst_req",   dm_req,     0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_inst",  inst_o,     0);
    chk("rst_data",  regcData_o, 0);
    chk("rst_addr",  dm_addr,    0);
    chk("rst_be",    dm_be,      0);
    @(negedge clk);
    dm_ack = 1'b0;
    op_i = 6'b000000;
    rst = 1'b1;

    // Directed: non-memory pass-through.
    @(negedge clk);
    op_i = 6'b000000; regcData_i = 32'h1234; regcWrite_i = 1'b1; regcAddr_i = 5'd5;
    #1;
    chk("nm_data", regcData_o, 32'h1234);
    chk("nm_wr",   regcWrite_o, 1);
    chk("nm_addr", regcAddr_o, 5);
    chk("nm_req",  dm_req, 0);
    chk("nm_stall", stallreq_o, 0);

    do_txn(OP_LW,  32'h100, 32'h0, 3, 32'hDEADBEEF);
    do_txn(OP_LB,  32'h103, 32'h0, 1, 32'h80AABBCC);
    do_txn(OP_LBU, 32'h103, 32'h0, 2, 32'h80AABBCC);
    do_txn(OP_LH,  32'h102, 32'h0, 1, 32'h80AABBCC);
    do_txn(OP_SH,  32'h202, 32'h0000ABCD, 2, 32'h0);
    do_txn(OP_LW,  32'h101, 32'h0, 1, 32'h0);
    do_txn(OP_SB,  32'h301, 32'h5A, 0, 32'h0);
    do_txn(OP_LW,  32'h400, 32'h0, 1, 32'h13579BDF);

    // Asynchronous reset in the middle of a request.
    @(negedge clk);
    set_inputs(OP_LW, 32'h500, 32'h0);
    dm_ack = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req",   dm_req,     0);
    chk("arst_stall", stallreq_o, 0);
    chk("arst_inst",  inst_o,     0);
    chk("arst_wr",    regcWrite_o, 0);
    @(negedge clk);
    rst = 1'b1;
    op_i = 6'b000000;
    #1;
    chk("post_rst_req",  dm_req, 0);
    chk("post_rst_inst", inst_o, inst_i);
    $display("txn reset mid-request");

    // Randomized mix against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [5:0]  op;
      logic [31:0] addr;
      int          sz;
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 31));
      else                           op = ops[$urandom_range(0, 7)];
      addr = $urandom;
      sz = size_of(op);
      if (sz > 1 && $urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
      do_txn(op, addr, $urandom, $urandom_range(1, 5), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
